// File: rtl/spi_exe_unit_2.sv
// SPI-slave execution unit: receives A, B and an opcode word over SPI, runs them through the ALU
// and returns {result, IF, ZF, OF, SF} on MISO within the same chip-select frame.
module spi_exe_unit_2 #(
  parameter int unsigned M           = 8,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk_p,
  input  logic i_rst,
  input  logic i_sclk,
  input  logic i_cs,
  input  logic i_mosi,
  output logic o_miso,
  output logic o_busy,
  output logic o_frame_done,
  output logic o_frame_err
);

  localparam int unsigned CW = $clog2(4 * M + 4);
  localparam int unsigned OW = M + 4;
  localparam logic [CW-1:0] LastA   = CW'(M - 1);
  localparam logic [CW-1:0] LastB   = CW'(2 * M - 1);
  localparam logic [CW-1:0] LastOp  = CW'(3 * M - 1);
  localparam logic [CW-1:0] LastBit = CW'(4 * M + 3);

  typedef enum logic [2:0] {StIdle, StRx, StExec, StTx, StWaitCs} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, vld_q;

  always_ff @(posedge i_clk_p) begin
    if (i_rst) begin
      sclk_sync_q <= {SYNC_STAGES{CPOL}};
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      vld_q       <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
      vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  logic sclk_cur, sclk_prv, cs_cur, cs_prv, mosi_cur;
  logic lead_edge, trail_edge, sample_edge, shift_edge, cs_fall;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   in_sh_q, in_sh_d, in_nxt;
  logic [M-1:0]   a_q, a_d, b_q, b_d, op_q, op_d, res_q, res_d;
  logic [OW-1:0]  out_sh_q, out_sh_d;
  logic           miso_q, miso_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic           skip_q, skip_d, armed_q;

  assign sclk_cur = sclk_sync_q[SYNC_STAGES-2];
  assign sclk_prv = sclk_sync_q[SYNC_STAGES-1];
  assign cs_cur   = cs_sync_q[SYNC_STAGES-2];
  assign cs_prv   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_cur = mosi_sync_q[SYNC_STAGES-1];

  // A frame may start only after a genuine high CS has passed the synchroniser, so a reset
  // while CS is low does not fabricate a CS fall from the cleared synchroniser.
  always_ff @(posedge i_clk_p) begin
    if (i_rst) armed_q <= 1'b0;
    else       armed_q <= armed_q | (vld_q[SYNC_STAGES-1] & cs_prv);
  end

  assign lead_edge   = (sclk_cur != sclk_prv) && (sclk_prv == CPOL);
  assign trail_edge  = (sclk_cur != sclk_prv) && (sclk_cur == CPOL) && !skip_q;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = armed_q && cs_prv && !cs_cur;
  assign in_nxt      = {in_sh_q[M-2:0], mosi_cur};

  logic [3:0]   opc;
  logic [M-1:0] alu_res;
  logic         f_if, f_zf, f_of, f_sf;

  assign opc = op_q[M-1 -: 4];

  always_comb begin
    alu_res = '0;
    f_of    = 1'b0;
    f_if    = 1'b0;
    case (opc)
      4'd0: begin
        alu_res = a_q + b_q;
        f_of    = (a_q[M-1] == b_q[M-1]) && (alu_res[M-1] != a_q[M-1]);
      end
      4'd1: begin
        alu_res = a_q - b_q;
        f_of    = (a_q[M-1] != b_q[M-1]) && (alu_res[M-1] != a_q[M-1]);
      end
      4'd2:    alu_res = a_q & b_q;
      4'd3:    alu_res = a_q | b_q;
      4'd4:    alu_res = a_q ^ b_q;
      4'd5:    alu_res = ~a_q;
      4'd6:    alu_res = {a_q[M-2:0], 1'b0};
      4'd7:    alu_res = {1'b0, a_q[M-1:1]};
      default: f_if = 1'b1;
    endcase
  end

  // An invalid opcode reports only IF; its forced-zero result does not raise ZF.
  assign f_zf = (alu_res == '0) && !f_if;
  assign f_sf = alu_res[M-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_sh_d  = in_sh_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    res_d    = res_q;
    out_sh_d = out_sh_q;
    miso_d   = miso_q;
    busy_d   = busy_q;
    skip_d   = skip_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d = StRx;
          cnt_d   = '0;
          in_sh_d = '0;
          busy_d  = 1'b1;
          skip_d  = (sclk_cur != CPOL);
        end
      end
      StRx, StExec, StTx: begin
        if (cs_cur) begin
          state_d = StIdle;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          miso_d  = 1'b0;
          skip_d  = 1'b0;
          in_sh_d = '0;
        end else begin
          if (skip_q && (sclk_cur != sclk_prv) && (sclk_cur == CPOL)) skip_d = 1'b0;
          if (state_q == StRx) begin
            if (sample_edge) begin
              in_sh_d = in_nxt;
              cnt_d   = cnt_q + CW'(1);
              if (cnt_q == LastA) a_d = in_nxt;
              if (cnt_q == LastB) b_d = in_nxt;
              if (cnt_q == LastOp) begin
                op_d    = in_nxt;
                state_d = StExec;
              end
            end
          end else if (state_q == StExec) begin
            res_d    = alu_res;
            out_sh_d = {alu_res, f_if, f_zf, f_of, f_sf};
            state_d  = StTx;
          end else begin
            if (shift_edge) begin
              miso_d   = out_sh_q[OW-1];
              out_sh_d = {out_sh_q[OW-2:0], 1'b0};
            end
            if (sample_edge) begin
              cnt_d = cnt_q + CW'(1);
              if (cnt_q == LastBit) begin
                done_d  = 1'b1;
                miso_d  = 1'b0;
                state_d = StWaitCs;
              end
            end
          end
        end
      end
      StWaitCs: begin
        miso_d = 1'b0;
        if (cs_cur) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk_p) begin
    if (i_rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      in_sh_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      res_q    <= '0;
      out_sh_q <= '0;
      miso_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      skip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      in_sh_q  <= in_sh_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      res_q    <= res_d;
      out_sh_q <= out_sh_d;
      miso_q   <= miso_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      skip_q   <= skip_d;
    end
  end

  assign o_miso       = miso_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;
  assign o_frame_err  = err_q;

endmodule

// File: tb/tb_spi_exe_unit_2.sv
// Directed bench for spi_exe_unit_2: three instances (M=8 mode 0, M=8 mode 3, M=16 mode 1)
// sharing SCLK/MOSI with separate chip selects.
module tb_spi_exe_unit_2;

  localparam int HALF = 80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic cs0 = 1'b1, cs1 = 1'b1, cs2 = 1'b1;
  logic miso0, busy0, done0, err0;
  logic miso1, busy1, done1, err1;
  logic miso2, busy2, done2, err2;

  int n_total = 0;
  int n_bad = 0;
  int done_cnt [3] = '{0, 0, 0};
  int err_cnt [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  spi_exe_unit_2 #(.M(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_m0 (
    .i_clk_p(clk), .i_rst(rst), .i_sclk(sclk), .i_cs(cs0), .i_mosi(mosi),
    .o_miso(miso0), .o_busy(busy0), .o_frame_done(done0), .o_frame_err(err0)
  );
  spi_exe_unit_2 #(.M(8), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) u_m3 (
    .i_clk_p(clk), .i_rst(rst), .i_sclk(sclk), .i_cs(cs1), .i_mosi(mosi),
    .o_miso(miso1), .o_busy(busy1), .o_frame_done(done1), .o_frame_err(err1)
  );
  spi_exe_unit_2 #(.M(16), .CPOL(1'b0), .CPHA(1'b1), .SYNC_STAGES(2)) u_m1 (
    .i_clk_p(clk), .i_rst(rst), .i_sclk(sclk), .i_cs(cs2), .i_mosi(mosi),
    .o_miso(miso2), .o_busy(busy2), .o_frame_done(done2), .o_frame_err(err2)
  );

  always @(posedge clk) begin
    if (done0) done_cnt[0] <= done_cnt[0] + 1;
    if (done1) done_cnt[1] <= done_cnt[1] + 1;
    if (done2) done_cnt[2] <= done_cnt[2] + 1;
    if (err0)  err_cnt[0]  <= err_cnt[0] + 1;
    if (err1)  err_cnt[1]  <= err_cnt[1] + 1;
    if (err2)  err_cnt[2]  <= err_cnt[2] + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic miso_of(input int inst);
    case (inst)
      0:       return miso0;
      1:       return miso1;
      default: return miso2;
    endcase
  endfunction

  task automatic set_cs(input int inst, input logic v);
    case (inst)
      0:       cs0 = v;
      1:       cs1 = v;
      default: cs2 = v;
    endcase
  endtask

  function automatic logic [95:0] pack(input int m, input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] op);
    logic [95:0] w;
    w = ({64'd0, a} << (2 * m)) | ({64'd0, b} << m) | {64'd0, op};
    return w;
  endfunction

  // Master: drives nbits SCLK periods with CS low; captures MISO for bits 3m and beyond.
  task automatic frame(input int inst, input int m, input bit cpol, input bit cpha,
                       input logic [95:0] word, input int nbits, output logic [35:0] resp);
    resp = '0;
    @(negedge clk);
    sclk = cpol;
    #(HALF);
    set_cs(inst, 1'b0);
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      logic bv;
      bv = (i < 3 * m) ? word[3 * m - 1 - i] : 1'b0;
      if (!cpha) begin
        mosi = bv;
        #(HALF);
        sclk = ~cpol;
        if (i >= 3 * m) resp = {resp[34:0], miso_of(inst)};
        #(HALF);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = bv;
        #(HALF);
        sclk = cpol;
        if (i >= 3 * m) resp = {resp[34:0], miso_of(inst)};
        #(HALF);
      end
    end
    mosi = 1'b0;
    #(HALF);
  endtask

  task automatic full_frame(input int inst, input int m, input bit cpol, input bit cpha,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] op,
                            input logic [35:0] exp, input string tag);
    logic [35:0] resp;
    int d0, e0;
    d0 = done_cnt[inst];
    e0 = err_cnt[inst];
    frame(inst, m, cpol, cpha, pack(m, a, b, op), 4 * m + 4, resp);
    check({tag, "_resp"}, resp, exp);
    check({tag, "_done"}, done_cnt[inst] - d0, 1);
    set_cs(inst, 1'b1);
    repeat (8) @(negedge clk);
    check({tag, "_err"}, err_cnt[inst] - e0, 0);
  endtask

  initial begin
    logic [35:0] resp;
    int d0, e0;
    logic seen;

    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_m0", {miso0, busy0, done0, err0}, 4'b0000);
    check("reset_m1", {miso2, busy2, done2, err2}, 4'b0000);
    repeat (8) @(negedge clk);

    // ADD 0x7F+0x01 with busy observed across the frame
    d0 = done_cnt[0];
    frame(0, 8, 1'b0, 1'b0, pack(8, 32'h7F, 32'h01, 32'h00), 36, resp);
    check("add_ovf_resp", resp, 36'h803);
    check("add_ovf_done", done_cnt[0] - d0, 1);
    check("add_ovf_busy_hi", busy0, 1'b1);
    cs0 = 1'b1;
    repeat (8) @(negedge clk);
    check("add_ovf_busy_lo", busy0, 1'b0);
    check("add_ovf_err", err_cnt[0], 0);

    full_frame(0, 8, 1'b0, 1'b0, 32'h05, 32'h05, 32'h10, 36'h004, "sub_zero");
    full_frame(0, 8, 1'b0, 1'b0, 32'h80, 32'h01, 32'h10, 36'h7F2, "sub_ovf");
    full_frame(1, 8, 1'b1, 1'b1, 32'h12, 32'h34, 32'hF0, 36'h008, "mode3_inv");
    full_frame(2, 16, 1'b0, 1'b1, 32'h8001, 32'h0000, 32'h6000, 36'h00020, "m16_shl");

    // Abort after 10 bits
    d0 = done_cnt[0];
    e0 = err_cnt[0];
    frame(0, 8, 1'b0, 1'b0, pack(8, 32'h11, 32'h22, 32'h00), 10, resp);
    cs0 = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_err", err_cnt[0] - e0, 1);
    check("abort_done", done_cnt[0] - d0, 0);
    check("abort_busy", busy0, 1'b0);
    check("abort_miso", miso0, 1'b0);
    repeat (4) @(negedge clk);
    full_frame(0, 8, 1'b0, 1'b0, 32'h03, 32'h04, 32'h00, 36'h070, "add_after_abort");

    // Reset while TX bit 3 is on MISO (OR 0xFF|0x00 keeps MISO high)
    d0 = done_cnt[0];
    e0 = err_cnt[0];
    frame(0, 8, 1'b0, 1'b0, pack(8, 32'hFF, 32'h00, 32'h30), 27, resp);
    check("pre_rst_miso", miso0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_tx_outputs", {miso0, busy0, done0, err0}, 4'b0000);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_no_restart", busy0, 1'b0);
    cs0 = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_no_pulses", {done_cnt[0] - d0, err_cnt[0] - e0}, 64'd0);
    full_frame(0, 8, 1'b0, 1'b0, 32'hF0, 32'h3C, 32'h20, 36'h300, "and_after_rst");

    // 40 extra SCLK edges after frame done
    d0 = done_cnt[0];
    e0 = err_cnt[0];
    frame(0, 8, 1'b0, 1'b0, pack(8, 32'h01, 32'h01, 32'h00), 36, resp);
    check("extra_resp", resp, 36'h020);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      sclk = ~sclk;
      #(HALF);
      if (miso0) seen = 1'b1;
    end
    check("extra_miso", seen, 1'b0);
    check("extra_done", done_cnt[0] - d0, 1);
    cs0 = 1'b1;
    repeat (8) @(negedge clk);
    check("extra_err", err_cnt[0] - e0, 0);
    check("extra_busy", busy0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
